// File: rtl/d3s_multi_dds_core.sv
// N-channel DDS phase-accumulator core: staged 2-word tuning words, one-shot phase adjust,
// sync-tick or immediate commit, and a common snapshot of all accumulators.
module d3s_multi_dds_core #(
   parameter int g_num_channels    = 4,
   parameter int g_acc_width       = 48,
   parameter int g_phase_out_width = 14,
   localparam int c_ch_w = (g_num_channels > 1) ? $clog2(g_num_channels) : 1
) (
   input  logic                                        clk_sys_i,
   input  logic                                        rst_n_a_i,
   input  logic                                        wr_i,
   input  logic [c_ch_w-1:0]                           ch_i,
   input  logic [1:0]                                  addr_i,
   input  logic [31:0]                                 data_i,
   input  logic                                        sync_i,
   input  logic                                        snap_i,
   output logic [g_num_channels*g_phase_out_width-1:0] phase_o,
   output logic [g_num_channels*g_acc_width-1:0]       snap_phase_o,
   output logic                                        snap_valid_o,
   output logic [g_num_channels-1:0]                   pending_o,
   output logic [g_num_channels-1:0]                   enabled_o
);

   localparam int W = g_acc_width;
   localparam int P = g_phase_out_width;

   typedef enum logic [1:0] {
      ADDR_FREQ_L    = 2'd0,
      ADDR_FREQ_H    = 2'd1,
      ADDR_PHASE_ADJ = 2'd2,
      ADDR_CTRL      = 2'd3
   } addr_e;

   // Asserts asynchronously, releases two clocks after rst_n_a_i rises.
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge clk_sys_i or negedge rst_n_a_i) begin
      if (!rst_n_a_i) r_rst_sync <= 2'b00;
      else            r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   logic w_ch_ok;
   if (g_num_channels == (1 << c_ch_w)) begin : g_ch_full
      assign w_ch_ok = 1'b1;
   end else begin : g_ch_part
      assign w_ch_ok = (ch_i < c_ch_w'(g_num_channels));
   end

   logic r_snap_valid;

   always_ff @(posedge clk_sys_i or negedge w_rst_n) begin
      if (!w_rst_n) r_snap_valid <= 1'b0;
      else          r_snap_valid <= snap_i;
   end
   assign snap_valid_o = r_snap_valid;

   for (genvar g = 0; g < g_num_channels; g++) begin : g_ch
      logic [W-1:0] r_acc, r_ftw, r_shadow, r_adj, r_snap;
      logic [P-1:0] r_phase;
      logic         r_adj_valid, r_pending, r_enable, r_immediate;
      logic         w_sel, w_wr_l, w_wr_h, w_wr_adj, w_wr_ctrl, w_commit;
      logic [W-1:0] w_acc_next;

      assign w_sel     = wr_i && w_ch_ok && (ch_i == c_ch_w'(g));
      assign w_wr_l    = w_sel && (addr_i == ADDR_FREQ_L);
      assign w_wr_h    = w_sel && (addr_i == ADDR_FREQ_H);
      assign w_wr_adj  = w_sel && (addr_i == ADDR_PHASE_ADJ);
      assign w_wr_ctrl = w_sel && (addr_i == ADDR_CTRL);
      // A FREQ_H write in the same cycle wins over the commit; the commit retries later.
      assign w_commit  = r_pending && (sync_i || r_immediate) && !w_wr_h;
      assign w_acc_next = r_acc + (r_enable ? r_ftw : '0) + (r_adj_valid ? r_adj : '0);

      // NOTE: every per-channel register, including the shadow/FTW words, is reset so that a
      // mid-run reset drops staged commits and adjusts; all state updates use <= only.
      always_ff @(posedge clk_sys_i or negedge w_rst_n) begin
         if (!w_rst_n) begin
            r_acc       <= '0;
            r_ftw       <= '0;
            r_shadow    <= '0;
            r_adj       <= '0;
            r_snap      <= '0;
            r_phase     <= '0;
            r_adj_valid <= 1'b0;
            r_pending   <= 1'b0;
            r_enable    <= 1'b0;
            r_immediate <= 1'b0;
         end else begin
            r_phase <= r_acc[W-1 -: P];
            if (snap_i) r_snap <= r_acc;

            if (w_wr_ctrl && data_i[2]) r_acc <= '0;
            else                        r_acc <= w_acc_next;

            // The adjust is consumed by the very next accumulate, so its valid lasts one cycle.
            r_adj_valid <= w_wr_adj;
            if (w_wr_adj) r_adj <= {{(W-32){data_i[31]}}, data_i};

            if (w_wr_l) r_shadow[31:0] <= data_i;
            if (w_wr_h) begin
               r_shadow[W-1:32] <= data_i[W-33:0];
               r_pending        <= 1'b1;
            end else if (w_commit) begin
               r_ftw     <= r_shadow;
               r_pending <= 1'b0;
            end

            if (w_wr_ctrl) begin
               r_enable    <= data_i[0];
               r_immediate <= data_i[1];
            end
         end
      end

      assign phase_o[g*P +: P]      = r_phase;
      assign snap_phase_o[g*W +: W] = r_snap;
      assign pending_o[g]           = r_pending;
      assign enabled_o[g]           = r_enable;
   end

endmodule

// File: tb/tb_d3s_multi_dds_core.sv
// Self-checking bench for d3s_multi_dds_core: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the channel rules.
module tb_d3s_multi_dds_core;

   localparam int N    = 4;
   localparam int W    = 48;
   localparam int P    = 14;
   localparam int CH_W = 2;

   localparam logic [1:0] A_L = 2'd0, A_H = 2'd1, A_ADJ = 2'd2, A_CTRL = 2'd3;

   logic              clk_sys_i = 1'b0;
   logic              rst_n_a_i;
   logic              wr_i;
   logic [CH_W-1:0]   ch_i;
   logic [1:0]        addr_i;
   logic [31:0]       data_i;
   logic              sync_i;
   logic              snap_i;
   logic [N*P-1:0]    phase_o;
   logic [N*W-1:0]    snap_phase_o;
   logic              snap_valid_o;
   logic [N-1:0]      pending_o;
   logic [N-1:0]      enabled_o;

   int tests = 0;
   int fails = 0;

   d3s_multi_dds_core #(
      .g_num_channels   (N),
      .g_acc_width      (W),
      .g_phase_out_width(P)
   ) dut (
      .clk_sys_i   (clk_sys_i),
      .rst_n_a_i   (rst_n_a_i),
      .wr_i        (wr_i),
      .ch_i        (ch_i),
      .addr_i      (addr_i),
      .data_i      (data_i),
      .sync_i      (sync_i),
      .snap_i      (snap_i),
      .phase_o     (phase_o),
      .snap_phase_o(snap_phase_o),
      .snap_valid_o(snap_valid_o),
      .pending_o   (pending_o),
      .enabled_o   (enabled_o)
   );

   always #5 clk_sys_i = ~clk_sys_i;

   // Reference model: what each channel holds after every clock edge.
   logic [W-1:0] m_acc [N];
   logic [W-1:0] m_ftw [N];
   logic [W-1:0] m_shadow [N];
   logic [W-1:0] m_adj [N];
   logic [W-1:0] m_snap [N];
   logic [P-1:0] m_phase [N];
   bit           m_adjv [N];
   bit           m_pend [N];
   bit           m_en [N];
   bit           m_imm [N];
   bit           m_snapv;

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin
         m_acc[c] = '0; m_ftw[c] = '0; m_shadow[c] = '0; m_adj[c] = '0;
         m_snap[c] = '0; m_phase[c] = '0;
         m_adjv[c] = 0; m_pend[c] = 0; m_en[c] = 0; m_imm[c] = 0;
      end
      m_snapv = 0;
   endtask

   // One clock edge: every decision below reads the state from before the edge.
   task automatic model_step();
      for (int c = 0; c < N; c++) begin
         bit sel;
         sel = wr_i && (int'(ch_i) == c);
         m_phase[c] = m_acc[c][W-1 -: P];
         if (snap_i) m_snap[c] = m_acc[c];
         if (sel && addr_i == A_CTRL && data_i[2])
            m_acc[c] = '0;
         else
            m_acc[c] = m_acc[c] + (m_en[c] ? m_ftw[c] : '0) + (m_adjv[c] ? m_adj[c] : '0);
         if (sel && addr_i == A_H) begin
            m_shadow[c] = (W'(data_i) << 32) | (m_shadow[c] & W'(64'hFFFF_FFFF));
            m_pend[c]   = 1;
         end else if (m_pend[c] && (sync_i || m_imm[c])) begin
            m_ftw[c]  = m_shadow[c];
            m_pend[c] = 0;
         end
         if (sel && addr_i == A_L)
            m_shadow[c] = (m_shadow[c] & ~W'(64'hFFFF_FFFF)) | W'(data_i);
         m_adjv[c] = sel && addr_i == A_ADJ;
         if (m_adjv[c]) m_adj[c] = W'(longint'($signed(data_i)));
         if (sel && addr_i == A_CTRL) begin
            m_en[c]  = data_i[0];
            m_imm[c] = data_i[1];
         end
      end
      m_snapv = snap_i;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      logic [N*P-1:0] e_ph;
      logic [N*W-1:0] e_sn;
      logic [N-1:0]   e_pd, e_en;
      for (int c = 0; c < N; c++) begin
         e_ph[c*P +: P] = m_phase[c];
         e_sn[c*W +: W] = m_snap[c];
         e_pd[c]        = m_pend[c];
         e_en[c]        = m_en[c];
      end
      check("phase_o", 256'(phase_o), 256'(e_ph));
      check("snap_phase_o", 256'(snap_phase_o), 256'(e_sn));
      check("snap_valid_o", 256'(snap_valid_o), 256'(m_snapv));
      check("pending_o", 256'(pending_o), 256'(e_pd));
      check("enabled_o", 256'(enabled_o), 256'(e_en));
   endtask

   // Inputs are stable across the edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk_sys_i);
      model_step();
      #1;
      wr_i   = 1'b0;
      sync_i = 1'b0;
      snap_i = 1'b0;
      compare_all();
   endtask

   task automatic wr(input int ch, input logic [1:0] addr, input logic [31:0] data,
                     input bit with_sync = 0);
      wr_i   = 1'b1;
      ch_i   = CH_W'(ch);
      addr_i = addr;
      data_i = data;
      sync_i = with_sync;
      tick();
   endtask

   task automatic snap_tick();
      snap_i = 1'b1;
      tick();
   endtask

   task automatic random_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            wr_i   = 1'b1;
            ch_i   = CH_W'($urandom_range(0, N - 1));
            addr_i = 2'($urandom_range(0, 3));
            data_i = (addr_i == A_CTRL) ? 32'($urandom_range(0, 7)) : $urandom;
         end
         sync_i = ($urandom_range(0, 7) == 0);
         snap_i = ($urandom_range(0, 3) == 0);
         tick();
      end
   endtask

   initial begin
      rst_n_a_i = 1'b0;
      wr_i = 1'b0; ch_i = '0; addr_i = '0; data_i = '0; sync_i = 1'b0; snap_i = 1'b0;
      model_reset();

      repeat (3) tick();
      rst_n_a_i = 1'b1;
      repeat (3) tick();

      // ch0: staged FTW committed on the sync tick, then free-running phase.
      wr(0, A_L, 32'h1000_0000);
      wr(0, A_H, 32'h0);
      check("ch0_pending_set", 256'(pending_o[0]), 256'(1));
      wr(0, A_CTRL, 32'h1);
      sync_i = 1'b1;
      tick();
      check("ch0_pending_clr", 256'(pending_o[0]), 256'(0));
      repeat (140) tick();

      // ch1: immediate mode, no sync needed.
      wr(1, A_CTRL, 32'h3);
      wr(1, A_L, 32'h0);
      wr(1, A_H, 32'h1);
      tick();
      repeat (16) tick();
      snap_tick();
      check("ch1_acc_16", 256'(snap_phase_o[1*W +: W]), 256'(48'h0010_0000_0000));

      // ch2: acc = 2, ftw = all ones -> next acc = 1.
      wr(2, A_CTRL, 32'h4);
      wr(2, A_ADJ, 32'h2);
      tick();
      wr(2, A_CTRL, 32'h2);
      wr(2, A_L, 32'hFFFF_FFFF);
      wr(2, A_H, 32'h0000_FFFF);
      tick();
      wr(2, A_CTRL, 32'h3);
      tick();
      snap_tick();
      check("ch2_wrap", 256'(snap_phase_o[2*W +: W]), 256'(48'h1));

      // ch0 collision: FREQ_H with sync in the same cycle keeps the old FTW pending.
      wr(0, A_L, 32'h0400_0000);
      wr(0, A_H, 32'h0, 1);
      check("ch0_collision_pend", 256'(pending_o[0]), 256'(1));
      repeat (5) tick();
      sync_i = 1'b1;
      tick();
      check("ch0_after_sync", 256'(pending_o[0]), 256'(0));
      repeat (5) tick();

      // ch3: phase adjust on a disabled channel, then clear+enable.
      wr(3, A_CTRL, 32'h2);
      wr(3, A_L, 32'h0000_0123);
      wr(3, A_H, 32'h0);
      tick();
      wr(3, A_CTRL, 32'h6);
      wr(3, A_ADJ, 32'h5);
      tick();
      wr(3, A_ADJ, 32'hFFFF_FFFF);
      tick();
      snap_tick();
      check("ch3_adj_minus1", 256'(snap_phase_o[3*W +: W]), 256'(48'h4));
      repeat (3) tick();
      wr(3, A_CTRL, 32'h5);
      snap_tick();
      check("ch3_cleared", 256'(snap_phase_o[3*W +: W]), 256'(48'h0));
      repeat (4) tick();

      // All channels running: back-to-back snapshots.
      snap_tick();
      snap_tick();
      check("snap_b2b_valid", 256'(snap_valid_o), 256'(1));
      tick();

      random_cycles(300);

      // Reset mid-run: outputs clear before any clock edge.
      @(posedge clk_sys_i);
      #3;
      rst_n_a_i = 1'b0;
      #1;
      model_reset();
      check("rst_phase_o", 256'(phase_o), 256'(0));
      check("rst_snap_phase_o", 256'(snap_phase_o), 256'(0));
      check("rst_snap_valid_o", 256'(snap_valid_o), 256'(0));
      check("rst_pending_o", 256'(pending_o), 256'(0));
      check("rst_enabled_o", 256'(enabled_o), 256'(0));
      repeat (2) tick();
      rst_n_a_i = 1'b1;
      repeat (3) tick();
      random_cycles(100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
